// File: rtl/pool_pkg.sv
// Shared types for the 2x2 average-pooling sequencer: pixel format,
// accumulator width and FSM state encoding.
package pool_pkg;

    localparam int PIX_W = 16;
    localparam int SUM_W = 18;

    typedef logic signed [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAST,
        ST_WR,
        ST_DONE
    } pool_state_t;

endpackage

// File: rtl/pool_2x2_ctrl_if.sv
// Memory-side bus of the pooling sequencer: a read port to the input
// feature map and a write port to the pooled output map.
interface pool_2x2_ctrl_if
    import pool_pkg::*;
#(
    parameter int RD_AW = 10,
    parameter int WR_AW = 8
);

    logic             rd_en;
    logic [RD_AW-1:0] rd_addr;
    pixel_t           rd_data;
    logic             wr_en;
    logic [WR_AW-1:0] wr_addr;
    pixel_t           wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );

endinterface

// File: rtl/pool_avg_2x2.sv
// Combinational 2x2 average: sum of four signed pixels, arithmetic shift
// right by two (rounds toward minus infinity).
module pool_avg_2x2
    import pool_pkg::*;
(
    input  pixel_t pix [4],
    output pixel_t avg
);

    logic signed [SUM_W-1:0] sext [4];
    logic signed [SUM_W-1:0] sum;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sext
            assign sext[gi] = {{(SUM_W - PIX_W){pix[gi][PIX_W-1]}}, pix[gi]};
        end
    endgenerate

    // Four 16-bit values fit in 18 bits, so the sum cannot wrap.
    assign sum = sext[0] + sext[1] + sext[2] + sext[3];
    assign avg = pixel_t'(sum >>> 2);

endmodule

// File: rtl/pool_2x2_ctrl.sv
// Raster-order 2x2 stride-2 average-pooling sequencer: four reads, one
// capture-only cycle and one write per window, then a one-cycle done pulse.
module pool_2x2_ctrl
    import pool_pkg::*;
#(
    parameter int N     = 28,
    parameter int RD_AW = $clog2(N * N),
    parameter int WR_AW = ((N / 2) * (N / 2) > 1) ? $clog2((N / 2) * (N / 2)) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    pool_2x2_ctrl_if.master mem
);

    localparam int M  = N / 2;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

    generate
        if (N < 2) begin : g_bad_n
            $error("pool_2x2_ctrl: N must be at least 2");
        end
    endgenerate

    pool_state_t   state_reg, state_next;
    logic [CW-1:0] r_reg, r_next;
    logic [CW-1:0] c_reg, c_next;
    logic [1:0]    k_reg, k_next;
    logic          cap_en;
    logic [1:0]    cap_idx;
    pixel_t        pix_w [4];
    pixel_t        avg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            r_reg     <= '0;
            c_reg     <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        r_next      = r_reg;
        c_next      = c_reg;
        k_next      = k_reg;
        busy        = 1'b0;
        done        = 1'b0;
        cap_en      = 1'b0;
        cap_idx     = 2'd3;
        mem.rd_en   = 1'b0;
        mem.rd_addr = '0;
        mem.wr_en   = 1'b0;
        mem.wr_addr = '0;
        mem.wr_data = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    r_next     = '0;
                    c_next     = '0;
                    k_next     = '0;
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                busy        = 1'b1;
                mem.rd_en   = 1'b1;
                mem.rd_addr = RD_AW'((2 * int'(r_reg) + int'(k_reg[1])) * N
                                     + 2 * int'(c_reg) + int'(k_reg[0]));
                // Data for the previous read arrives now (latency 1).
                cap_en      = (k_reg != 2'd0);
                cap_idx     = k_reg - 2'd1;
                k_next      = k_reg + 2'd1;
                if (k_reg == 2'd3) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                busy       = 1'b1;
                cap_en     = 1'b1;
                cap_idx    = 2'd3;
                state_next = ST_WR;
            end
            ST_WR: begin
                busy        = 1'b1;
                mem.wr_en   = 1'b1;
                mem.wr_addr = WR_AW'(int'(r_reg) * M + int'(c_reg));
                mem.wr_data = avg;
                k_next      = '0;
                if (c_reg == LAST_IDX) begin
                    c_next = '0;
                    if (r_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        r_next     = r_reg + CW'(1);
                        state_next = ST_RD;
                    end
                end else begin
                    c_next     = c_reg + CW'(1);
                    state_next = ST_RD;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cap
            pixel_t pix_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pix_reg <= '0;
                end else if (cap_en && cap_idx == 2'(gi)) begin
                    pix_reg <= mem.rd_data;
                end
            end
            assign pix_w[gi] = pix_reg;
        end
    endgenerate

    pool_avg_2x2 u_avg (
        .pix (pix_w),
        .avg (avg)
    );

endmodule

// File: tb/tb_pool_2x2_ctrl.sv
// Bench for pool_2x2_ctrl: three instances (N=4, 5, 2) fed from behavioural
// memories; every observed read/write/done/busy is compared to a reference.
module tb_pool_2x2_ctrl;
    import pool_pkg::*;

    typedef struct {
        int d;
        int kind;   // 0 read, 1 write, 2 done, 3 busy, 4 strobe-low field nonzero
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic st [3];
    logic busy_v [3];
    logic done_v [3];
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    ev_t  ev_q [$];
    logic signed [15:0] mem [3][25];

    always @(posedge clk) cyc <= cyc + 1;

    pool_2x2_ctrl_if #(.RD_AW(4), .WR_AW(2)) bus0 ();
    pool_2x2_ctrl_if #(.RD_AW(5), .WR_AW(2)) bus1 ();
    pool_2x2_ctrl_if #(.RD_AW(2), .WR_AW(1)) bus2 ();

    pool_2x2_ctrl #(.N(4), .RD_AW(4), .WR_AW(2)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .busy(busy_v[0]), .done(done_v[0]), .mem(bus0));
    pool_2x2_ctrl #(.N(5), .RD_AW(5), .WR_AW(2)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .busy(busy_v[1]), .done(done_v[1]), .mem(bus1));
    pool_2x2_ctrl #(.N(2), .RD_AW(2), .WR_AW(1)) dut2 (
        .clk(clk), .rst(rst), .start(st[2]), .busy(busy_v[2]), .done(done_v[2]), .mem(bus2));

    // Read memories: one-cycle latency, garbage whenever no read was issued.
    always @(posedge clk) begin
        bus0.rd_data <= bus0.rd_en ? mem[0][int'(bus0.rd_addr)] : pixel_t'($urandom);
        bus1.rd_data <= bus1.rd_en ? mem[1][int'(bus1.rd_addr)] : pixel_t'($urandom);
        bus2.rd_data <= bus2.rd_en ? mem[2][int'(bus2.rd_addr)] : pixel_t'($urandom);
    end

    function automatic void push_ev(int d, int kind, int a, int v);
        ev_t e;
        e.d = d; e.kind = kind; e.cyc = cyc; e.addr = a; e.data = v;
        ev_q.push_back(e);
    endfunction

    task automatic mon(input int d, input logic b, input logic dn, input logic re, input int ra,
                       input logic we, input int wa, input int wd);
        if (re === 1'b1) push_ev(d, 0, ra, 0);
        if (we === 1'b1) push_ev(d, 1, wa, wd);
        if (dn === 1'b1) push_ev(d, 2, 0, 0);
        if (b === 1'b1) push_ev(d, 3, 0, 0);
        if ((re !== 1'b1 && ra != 0) || (we !== 1'b1 && (wa != 0 || wd != 0))) push_ev(d, 4, 0, 0);
    endtask

    always @(negedge clk) begin
        mon(0, busy_v[0], done_v[0], bus0.rd_en, int'(bus0.rd_addr), bus0.wr_en,
            int'(bus0.wr_addr), int'(bus0.wr_data));
        mon(1, busy_v[1], done_v[1], bus1.rd_en, int'(bus1.rd_addr), bus1.wr_en,
            int'(bus1.wr_addr), int'(bus1.wr_data));
        mon(2, busy_v[2], done_v[2], bus2.rd_en, int'(bus2.rd_addr), bus2.wr_en,
            int'(bus2.wr_addr), int'(bus2.wr_data));
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        nchk++;
        assert (obs === 32'(exp)) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: mean of the 2x2 window, rounded toward minus infinity.
    function automatic int ref_avg(int d, int n, int r, int c);
        int s = 0;
        int q;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                s += int'(mem[d][(2 * r + dr) * n + 2 * c + dc]);
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic check_pass(input int d, input int n, input int t, input string nm, input bit excl);
        int m, lo, hi, vio, outside, odd_rd;
        int wa[$], wd[$], wc[$], ra[$], rc[$], dc[$], bc[$];
        m = n / 2; lo = t + 1; hi = t + 6 * m * m + 1;
        vio = 0; outside = 0; odd_rd = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].d != d) continue;
            if (ev_q[i].cyc < lo || ev_q[i].cyc > hi) begin
                if (ev_q[i].kind <= 3) outside++;
                continue;
            end
            case (ev_q[i].kind)
                0: begin
                    ra.push_back(ev_q[i].addr); rc.push_back(ev_q[i].cyc);
                    if ((ev_q[i].addr % n) >= 2 * m || ev_q[i].addr >= 2 * m * n) odd_rd++;
                end
                1: begin
                    wa.push_back(ev_q[i].addr); wd.push_back(ev_q[i].data); wc.push_back(ev_q[i].cyc);
                end
                2: dc.push_back(ev_q[i].cyc);
                3: bc.push_back(ev_q[i].cyc);
                default: vio++;
            endcase
        end
        chk({nm, ".nwr"}, wa.size(), m * m);
        for (int i = 0; i < wa.size() && i < m * m; i++) begin
            chk($sformatf("%s.wa%0d", nm, i), wa[i], i);
            chk($sformatf("%s.wd%0d", nm, i), wd[i], ref_avg(d, n, i / m, i % m));
            chk($sformatf("%s.wc%0d", nm, i), wc[i], t + 6 * (i + 1));
        end
        chk({nm, ".nrd"}, ra.size(), 4 * m * m);
        for (int i = 0; i < ra.size() && i < 4 * m * m; i++) begin
            int w = i / 4;
            int k = i % 4;
            chk($sformatf("%s.ra%0d", nm, i), ra[i],
                (2 * (w / m) + k / 2) * n + 2 * (w % m) + k % 2);
            chk($sformatf("%s.rc%0d", nm, i), rc[i], t + 1 + 6 * w + k);
        end
        chk({nm, ".odd_rd"}, odd_rd, 0);
        chk({nm, ".ndone"}, dc.size(), 1);
        if (dc.size() > 0) chk({nm, ".done_cyc"}, dc[0], hi);
        chk({nm, ".nbusy"}, bc.size(), 6 * m * m);
        if (bc.size() > 0) begin
            chk({nm, ".busy_first"}, bc[0], lo);
            chk({nm, ".busy_last"}, bc[bc.size() - 1], hi - 1);
        end
        chk({nm, ".idle_zero"}, vio, 0);
        if (excl) chk({nm, ".outside"}, outside, 0);
    endtask

    task automatic wait_done(input int d, input string nm);
        int seen = 0;
        for (int i = 0; i < 2000 && seen == 0; i++) begin
            @(negedge clk);
            if (done_v[d] === 1'b1) seen = 1;
        end
        chk({nm, ".done_seen"}, seen, 1);
    endtask

    task automatic launch(input int d, output int t);
        @(posedge clk); #1;
        ev_q.delete();
        t = cyc;
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
    endtask

    task automatic run_pass(input int d, input int n, input string nm);
        int t;
        launch(d, t);
        wait_done(d, nm);
        repeat (8) @(posedge clk);
        check_pass(d, n, t, nm, 1'b1);
    endtask

    task automatic fill_rand(input int d);
        for (int i = 0; i < 25; i++) mem[d][i] = 16'($urandom);
    endtask

    task automatic fill_ramp(input int d);
        for (int i = 0; i < 25; i++) mem[d][i] = 16'(i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2, nw, nr;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) st[d] = 1'b0;
        for (int d = 0; d < 3; d++) fill_rand(d);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", busy_v[0], 0);
        chk("rst.done", done_v[0], 0);
        chk("rst.rd_en", bus0.rd_en, 0);
        chk("rst.rd_addr", bus0.rd_addr, 0);
        chk("rst.wr_en", bus0.wr_en, 0);
        chk("rst.wr_addr", bus0.wr_addr, 0);
        chk("rst.wr_data", bus0.wr_data, 0);
        chk("rst.busy1", busy_v[1], 0);
        chk("rst.busy2", busy_v[2], 0);
        @(posedge clk); #1;
        rst = 1'b0;

        fill_ramp(0);
        run_pass(0, 4, "ramp4");

        fill_rand(0);
        mem[0][0] = -16'sd1; mem[0][1] = -16'sd2; mem[0][4] = -16'sd3; mem[0][5] = -16'sd4;
        run_pass(0, 4, "neg4");
        chk("neg4.explicit", ref_avg(0, 4, 0, 0), -3);

        for (int i = 0; i < 25; i++) mem[0][i] = 16'sh7fff;
        run_pass(0, 4, "max4");
        for (int i = 0; i < 25; i++) mem[0][i] = 16'sh8000;
        run_pass(0, 4, "min4");

        for (int p = 0; p < 3; p++) begin
            fill_rand(0);
            run_pass(0, 4, $sformatf("rnd4_%0d", p));
        end

        fill_ramp(1);
        run_pass(1, 5, "ramp5");
        fill_rand(1);
        run_pass(1, 5, "rnd5");

        fill_ramp(2);
        run_pass(2, 2, "ramp2");
        for (int p = 0; p < 2; p++) begin
            fill_rand(2);
            run_pass(2, 2, $sformatf("rnd2_%0d", p));
        end

        // start held through DONE and the following IDLE cycle: exactly two passes
        fill_rand(0);
        @(posedge clk); #1;
        ev_q.delete();
        t = cyc;
        st[0] = 1'b1;
        wait_done(0, "hold1");
        @(posedge clk); #1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        t2 = t + 6 * 4 + 2;
        wait_done(0, "hold2");
        repeat (40) @(posedge clk);
        check_pass(0, 4, t, "hold1", 1'b0);
        check_pass(0, 4, t2, "hold2", 1'b0);
        nw = 0; nr = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].d == 0 && ev_q[i].kind == 1) nw++;
            if (ev_q[i].d == 0 && ev_q[i].kind == 0) nr++;
        end
        chk("hold.total_wr", nw, 8);
        chk("hold.total_rd", nr, 32);

        // start pulse while busy is not queued
        fill_rand(1);
        launch(1, t);
        repeat (9) @(posedge clk); #1;
        st[1] = 1'b1;
        @(posedge clk); #1;
        st[1] = 1'b0;
        wait_done(1, "busy_start");
        repeat (30) @(posedge clk);
        check_pass(1, 5, t, "busy_start", 1'b1);

        // reset during the second window's reads
        fill_rand(0);
        launch(0, t);
        repeat (7) @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.busy", busy_v[0], 0);
        chk("midrst.done", done_v[0], 0);
        chk("midrst.rd_en", bus0.rd_en, 0);
        chk("midrst.rd_addr", bus0.rd_addr, 0);
        chk("midrst.wr_en", bus0.wr_en, 0);
        chk("midrst.wr_addr", bus0.wr_addr, 0);
        chk("midrst.wr_data", bus0.wr_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        nw = 0; nr = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].d == 0 && ev_q[i].kind == 1) nw++;
            if (ev_q[i].d == 0 && ev_q[i].kind == 0 && ev_q[i].cyc > t + 8) nr++;
        end
        chk("midrst.writes", nw, 1);
        chk("midrst.late_rd", nr, 0);
        fill_rand(0);
        run_pass(0, 4, "after_rst");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
